// File: rtl/ndp_sim_pkt_gen.sv
// AXI4-Stream test packet source: fixed-length packets, NetFPGA tuser, indexed payload.
// Optional define NDP_SIM_PKT_GEN_THROTTLE_EN adds a one-cycle bubble after every non-last beat.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | run parameters latched, first beat being prepared
// SEND   | presenting beats of the current packet
// GAP    | inter-frame idle cycles
// DONE   | one-cycle completion pulse
module ndp_sim_pkt_gen #(
  parameter int         C_M_AXIS_DATA_WIDTH  = 256,
  parameter int         C_M_AXIS_TUSER_WIDTH = 128,
  parameter logic [7:0] SRC_PORT             = 8'h01,
  parameter logic [7:0] DST_PORT             = 8'h04,
  parameter int         IFG_CYCLES           = 4
) (
  input  logic                              axis_aclk,
  input  logic                              axis_resetn,
  input  logic                              start,
  input  logic [15:0]                       pkt_count,
  input  logic [15:0]                       pkt_len,
  output logic                              busy,
  output logic                              done,
  output logic [31:0]                       sent_count,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast
);

  localparam int KW  = C_M_AXIS_DATA_WIDTH / 8;
  localparam int REP = C_M_AXIS_DATA_WIDTH / 32;

`ifdef NDP_SIM_PKT_GEN_THROTTLE_EN
  localparam bit THROTTLE = 1'b1;
`else
  localparam bit THROTTLE = 1'b0;
`endif

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    state;
  logic [15:0]   count_q;
  logic [15:0]   len_q;
  logic [15:0]   pkt_idx;
  logic [15:0]   beat_idx;
  logic [15:0]   gap_cnt;
  logic [15:0]   beats;
  logic [15:0]   nxt_p;
  logic [15:0]   nxt_b;
  logic [4:0]    rem;
  logic [KW-1:0] last_keep;
  logic          hs;
  logic          pkt_end;
  logic          last_pkt;
  logic          load_en;

  function automatic logic [15:0] clamp_len(input logic [15:0] len);
    if (len < 16'd64)   return 16'd64;
    if (len > 16'd9600) return 16'd9600;
    return len;
  endfunction

  // len_q is clamped to 9600, so the +31 cannot overflow 16 bits
  assign beats     = (len_q + 16'd31) >> 5;
  assign rem       = len_q[4:0];
  assign last_keep = (rem == 5'd0) ? '1 : ((KW'(1) << rem) - KW'(1));
  assign hs        = m_axis_tvalid & m_axis_tready;
  assign pkt_end   = hs & m_axis_tlast;
  assign last_pkt  = (pkt_idx + 16'd1) == count_q;

  // Selects which beat (if any) gets registered onto the bus this cycle
  always_comb begin
    load_en = 1'b0;
    nxt_p   = pkt_idx;
    nxt_b   = beat_idx;
    case (state)
      S_LOAD: begin
        nxt_p   = '0;
        nxt_b   = '0;
        load_en = (count_q != 16'd0);
      end
      S_SEND: begin
        if (pkt_end) begin
          nxt_p   = pkt_idx + 16'd1;
          nxt_b   = '0;
          load_en = (IFG_CYCLES == 0) && !last_pkt;
        end else if (hs) begin
          nxt_b   = beat_idx + 16'd1;
          load_en = !THROTTLE;
        end else if (!m_axis_tvalid) begin
          load_en = 1'b1;
        end
      end
      S_GAP:   load_en = (gap_cnt == 16'd0);
      default: ;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      sent_count    <= '0;
      count_q       <= '0;
      len_q         <= '0;
      pkt_idx       <= '0;
      beat_idx      <= '0;
      gap_cnt       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
    end else begin
      done     <= 1'b0;
      pkt_idx  <= nxt_p;
      beat_idx <= nxt_b;

      if (load_en) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= {REP{nxt_p, nxt_b}};
        m_axis_tkeep  <= (nxt_b == beats - 16'd1) ? last_keep : '1;
        m_axis_tlast  <= (nxt_b == beats - 16'd1);
      end else if (hs) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end

      if (pkt_end) sent_count <= sent_count + 32'd1;

      case (state)
        S_IDLE: begin
          if (start) begin
            len_q   <= clamp_len(pkt_len);
            count_q <= pkt_count;
            busy    <= 1'b1;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          m_axis_tuser <= {{(C_M_AXIS_TUSER_WIDTH-32){1'b0}}, DST_PORT, SRC_PORT, len_q};
          if (count_q == 16'd0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= S_SEND;
          end
        end
        S_SEND: begin
          if (pkt_end) begin
            if (last_pkt) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (IFG_CYCLES != 0) begin
              state   <= S_GAP;
              gap_cnt <= 16'(IFG_CYCLES - 1);
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == 16'd0) state <= S_SEND;
          else                  gap_cnt <= gap_cnt - 16'd1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ndp_sim_pkt_gen.sv
// Directed self-checking bench for ndp_sim_pkt_gen (default build, IFG_CYCLES=4).
module tb_ndp_sim_pkt_gen;

  logic         clk = 1'b0;
  logic         axis_resetn;
  logic         start;
  logic [15:0]  pkt_count;
  logic [15:0]  pkt_len;
  logic         busy;
  logic         done;
  logic [31:0]  sent_count;
  logic [255:0] tdata;
  logic [31:0]  tkeep;
  logic [127:0] tuser;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  always #5 clk = ~clk;

  ndp_sim_pkt_gen dut (
    .axis_aclk     (clk),
    .axis_resetn   (axis_resetn),
    .start         (start),
    .pkt_count     (pkt_count),
    .pkt_len       (pkt_len),
    .busy          (busy),
    .done          (done),
    .sent_count    (sent_count),
    .m_axis_tdata  (tdata),
    .m_axis_tkeep  (tkeep),
    .m_axis_tuser  (tuser),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast)
  );

  typedef struct {
    logic [31:0] word;
    logic [31:0] keep;
    logic        last;
    logic [31:0] user;
    logic        rep_ok;
  } beat_t;

  beat_t beats_q[$];
  int    gaps_q[$];
  beat_t mb;
  int    done_cnt  = 0;
  int    valid_cnt = 0;
  bit    in_gap    = 1'b0;
  int    gap_run   = 0;
  int    n_chk     = 0;
  int    n_fail    = 0;
  int    exp_sent  = 0;

  // Bus monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      in_gap = 1'b0;
    end
    if (tvalid) begin
      valid_cnt++;
      if (in_gap) begin
        gaps_q.push_back(gap_run);
        in_gap = 1'b0;
      end
      if (tready) begin
        mb.word   = tdata[31:0];
        mb.keep   = tkeep;
        mb.last   = tlast;
        mb.user   = tuser[31:0];
        mb.rep_ok = (tdata == {8{tdata[31:0]}});
        beats_q.push_back(mb);
        if (tlast) begin
          in_gap  = 1'b1;
          gap_run = 0;
        end
      end
    end else if (in_gap) begin
      gap_run++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] cnt, input logic [15:0] len);
    @(posedge clk);
    #1;
    start     = 1'b1;
    pkt_count = cnt;
    pkt_len   = len;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        check("busy_at_done", busy, 0);
      end
    end
    check("done_seen", seen, 1);
    @(negedge clk);
  endtask

  task automatic wait_word(input logic [31:0] word, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (tvalid && tdata[31:0] == word) seen = 1'b1;
    end
    check("beat_seen", seen, 1);
  endtask

  initial begin
    int base;
    int gbase;
    int d0;
    int v0;
    int bad;

    axis_resetn = 1'b0;
    start       = 1'b0;
    pkt_count   = '0;
    pkt_len     = '0;
    tready      = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_tvalid", tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sent", sent_count, 0);
    check("rst_tdata_zero", (tdata == '0), 1);
    check("rst_tuser_zero", (tuser == '0), 1);
    axis_resetn = 1'b1;

    // len=64, count=1: two full beats, latency N+2
    base = beats_q.size();
    d0   = done_cnt;
    do_start(16'd1, 16'd64);
    @(negedge clk);
    check("lat_n1_busy", busy, 1);
    check("lat_n1_tvalid", tvalid, 0);
    @(negedge clk);
    check("lat_n2_tvalid", tvalid, 1);
    wait_done(50);
    exp_sent += 1;
    check("t1_nbeats", beats_q.size() - base, 2);
    check("t1_b0_word", beats_q[base].word, 32'h0000_0000);
    check("t1_b0_keep", beats_q[base].keep, 32'hFFFF_FFFF);
    check("t1_b0_last", beats_q[base].last, 0);
    check("t1_b1_word", beats_q[base+1].word, 32'h0000_0001);
    check("t1_b1_keep", beats_q[base+1].keep, 32'hFFFF_FFFF);
    check("t1_b1_last", beats_q[base+1].last, 1);
    check("t1_tuser", beats_q[base].user, 32'h0401_0040);
    check("t1_rep", beats_q[base+1].rep_ok, 1);
    check("t1_done_cnt", done_cnt - d0, 1);
    check("t1_sent", sent_count, exp_sent);

    // len=65: partial last beat
    base = beats_q.size();
    do_start(16'd1, 16'd65);
    wait_done(50);
    exp_sent += 1;
    check("t2_nbeats", beats_q.size() - base, 3);
    check("t2_b1_keep", beats_q[base+1].keep, 32'hFFFF_FFFF);
    check("t2_b1_last", beats_q[base+1].last, 0);
    check("t2_b2_keep", beats_q[base+2].keep, 32'h0000_0001);
    check("t2_b2_last", beats_q[base+2].last, 1);
    check("t2_b2_word", beats_q[base+2].word, 32'h0000_0002);
    check("t2_len", beats_q[base].user[15:0], 16'h0041);

    // len=128 with a 10-cycle stall on beat 1
    base   = beats_q.size();
    tready = 1'b0;
    do_start(16'd1, 16'd128);
    wait_word(32'h0000_0000, 20);
    @(posedge clk);
    #1 tready = 1'b1;
    @(posedge clk);
    #1 tready = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(tvalid && tdata == {8{32'h0000_0001}} && tkeep == 32'hFFFF_FFFF && !tlast)) bad++;
    end
    check("t3_stall_stable", bad, 0);
    check("t3_stall_word", tdata[31:0], 32'h0000_0001);
    tready = 1'b1;
    wait_done(50);
    exp_sent += 1;
    check("t3_nbeats", beats_q.size() - base, 4);
    check("t3_b2_last", beats_q[base+2].last, 0);
    check("t3_b3_word", beats_q[base+3].word, 32'h0000_0003);
    check("t3_b3_last", beats_q[base+3].last, 1);

    // count=3: inter-frame gap and packet index in payload
    base  = beats_q.size();
    gbase = gaps_q.size();
    do_start(16'd3, 16'd64);
    wait_done(100);
    exp_sent += 3;
    check("t4_nbeats", beats_q.size() - base, 6);
    check("t4_ngaps", gaps_q.size() - gbase, 2);
    check("t4_gap0", gaps_q[gbase], 4);
    check("t4_gap1", gaps_q[gbase+1], 4);
    check("t4_p0_word", beats_q[base].word, 32'h0000_0000);
    check("t4_p1_word", beats_q[base+2].word, 32'h0001_0000);
    check("t4_p2_word", beats_q[base+4].word, 32'h0002_0000);
    check("t4_p2_b1_word", beats_q[base+5].word, 32'h0002_0001);
    check("t4_sent", sent_count, exp_sent);

    // count=0: done at N+2, no beats
    v0 = valid_cnt;
    d0 = done_cnt;
    do_start(16'd0, 16'd64);
    @(negedge clk);
    check("t5_n1_done", done, 0);
    @(negedge clk);
    check("t5_n2_done", done, 1);
    check("t5_n2_busy", busy, 0);
    @(negedge clk);
    check("t5_no_valid", valid_cnt - v0, 0);
    check("t5_done_cnt", done_cnt - d0, 1);

    // start while busy is ignored
    base = beats_q.size();
    d0   = done_cnt;
    do_start(16'd2, 16'd64);
    repeat (2) @(posedge clk);
    #1;
    check("t5_busy_mid", busy, 1);
    do_start(16'd5, 16'd200);
    wait_done(100);
    repeat (20) @(negedge clk);
    exp_sent += 2;
    check("t5_nbeats", beats_q.size() - base, 4);
    check("t5_len_kept", beats_q[base+3].user[15:0], 16'h0040);
    check("t5_done_cnt2", done_cnt - d0, 1);
    check("t5_sent", sent_count, exp_sent);

    // reset during beat 1 of a 4-beat packet
    do_start(16'd1, 16'd128);
    wait_word(32'h0000_0001, 20);
    #1 axis_resetn = 1'b0;
    #1;
    check("t6_tvalid", tvalid, 0);
    check("t6_tlast", tlast, 0);
    check("t6_tdata_zero", (tdata == '0), 1);
    check("t6_tkeep", tkeep, 0);
    check("t6_tuser_zero", (tuser == '0), 1);
    check("t6_busy", busy, 0);
    check("t6_sent", sent_count, 0);
    @(negedge clk);
    axis_resetn = 1'b1;
    exp_sent    = 0;
    base        = beats_q.size();
    do_start(16'd1, 16'd64);
    wait_done(50);
    exp_sent += 1;
    check("t6_nbeats", beats_q.size() - base, 2);
    check("t6_b0_word", beats_q[base].word, 32'h0000_0000);
    check("t6_sent_after", sent_count, exp_sent);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ndp_sim_pkt_gen.md
Name: ndp_sim_pkt_gen

Overview:
Synthesizable AXI4-Stream test packet source for NDP switch simulation and bring-up. It sits directly downstream of the bench clock/reset generation and upstream of the NDP datapath input port. On a start pulse it emits a programmed number of fixed-length packets with NetFPGA-style tuser metadata and a deterministic, self-checking payload pattern. It also provides an inter-frame gap, progress counters and a done pulse.

Parameters:
C_M_AXIS_DATA_WIDTH, 256, tdata width in bits; fixed 256 for this block.
C_M_AXIS_TUSER_WIDTH, 128, tuser width in bits.
SRC_PORT, 8'h01, one-hot source port placed in tuser[23:16].
DST_PORT, 8'h04, one-hot destination port placed in tuser[31:24].
IFG_CYCLES, 4, idle cycles between tlast acceptance and the next packet's first beat; 0 is legal.

Ports:
axis_aclk  in  1  single clock for all logic
axis_resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a run; ignored while busy=1
pkt_count  in  16  number of packets in the run; sampled on start
pkt_len  in  16  packet length in bytes; sampled on start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the run completes
sent_count  out  32  total packets fully accepted since reset; wraps
m_axis_tdata  out  256  payload
m_axis_tkeep  out  32  byte enables
m_axis_tuser  out  128  [15:0]=length, [23:16]=SRC_PORT, [31:24]=DST_PORT, rest 0
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last beat of packet

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; busy, done, tvalid, tlast=0; tdata, tkeep, tuser=0; sent_count=0; internal pkt_idx and beat_idx=0.
- FSM states: IDLE, LOAD, SEND, GAP, DONE.
- IDLE: when start=1, latch pkt_count and pkt_len, then go to LOAD.
- Length clamp, applied at latch: len<64 becomes 64; len>9600 becomes 9600.
- LOAD: busy=1. Compute beats = ceil(len/32) and clear pkt_idx. If the latched count is 0, go to DONE; otherwise go to SEND.
- Latency: start at cycle N puts the first tvalid at cycle N+2.
- SEND beat content:
  - tdata = 8 copies of {pkt_idx[15:0], beat_idx[15:0]}.
  - tuser is held constant for the whole packet.
  - tkeep = all ones, except on the last beat when len mod 32 = r != 0, where tkeep = (1<<r)-1.
  - tlast = 1 only on beat beats-1.
- AXIS rules:
  - Once tvalid=1, tvalid and all sideband signals are held stable until tvalid&&tready.
  - The block never deasserts tvalid without a handshake.
  - Registered outputs only; no combinational path from tready to tvalid.
- Handshake on a non-last beat: increment beat_idx.
- Handshake on the last beat:
  - sent_count+1, pkt_idx+1, beat_idx=0.
  - If pkt_idx+1 equals the latched count, go to DONE. Else go to GAP, or straight to SEND when IFG_CYCLES=0.
- GAP: tvalid=0 for exactly IFG_CYCLES cycles, then SEND.
- DONE: done=1 for one cycle, busy=0, return to IDLE. A start pulse in that same cycle is ignored.
- A start pulse while busy=1 is ignored; it does not modify the latched values.
- sent_count wraps from 2^32-1 to 0.
- Reset mid-packet: outputs clear immediately. The partial packet is abandoned; the downstream side must tolerate a truncated packet in simulation. The next run restarts at pkt_idx 0.

Optional Feature:
NDP_SIM_PKT_GEN_THROTTLE_EN
- Defined: after every accepted beat that is not tlast, tvalid is held low for one cycle before the next beat. This gives roughly 50% source throttling for exercising downstream bubble handling. Stability rules are unchanged.
- Not defined: beats are back-to-back whenever tready=1.

Test Plan:
1. len=64, count=1, tready=1:
   - 2 beats with tkeep=FFFFFFFF and tlast on beat 1; tuser[31:0]=0x04010040.
   - Beat 0 tdata word = 0x00000000, beat 1 = 0x00000001.
   - done pulses once; sent_count=1.
2. len=65, count=1 -> 3 beats; last tkeep=0x00000001; tuser[15:0]=0x0041.
3. len=128, count=1, tready low for 10 cycles after beat 1 is presented -> tdata, tkeep, tlast stay constant throughout; tvalid stays 1; 4 beats are delivered in total.
4. count=3, len=64, IFG_CYCLES=4 -> exactly 4 tvalid=0 cycles between each tlast handshake and the next first beat; beat 0 words are 0x00000000, 0x00010000, 0x00020000; sent_count=3.
5. count=0 -> done two cycles after start with no tvalid; a second start while busy during a count=2 run -> exactly 2 packets are sent.
6. Assert axis_resetn=0 mid-beat 1 of a 4-beat packet -> all outputs 0 in the same cycle; a new start after release emits pkt_idx 0 and sent_count counts from 0.
